// File: rtl/cfg_rom_pkg.sv
// cfg_rom_pkg: shared state type and read-latency helpers for the ROM stream reader.
package cfg_rom_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   function automatic int rd_lat(input logic [1:0] rdtype);
      return rdtype == 2'd0 ? 0 : rdtype == 2'd3 ? 2 : 1;
   endfunction
   // one slot per in-flight read plus two so a steady stream never runs out of credit
   function automatic int fifo_depth(input logic [1:0] rdtype);
      return rd_lat(rdtype) + 2;
   endfunction
endpackage

// File: rtl/cfg_sync_fifo.sv
// cfg_sync_fifo: synchronous FIFO, arbitrary depth; a pop frees the slot for a same-cycle push when full.
module cfg_sync_fifo
   import cfg_rom_pkg::*;
#(
   parameter int W = 33,
   parameter int DEPTH = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [W-1:0]                   wr_data,
   input  logic                           rd_en,
   output logic [W-1:0]                   rd_data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic do_wr, do_rd;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = mem[rptr];
   always_ff @(posedge clk)
      if (do_wr) mem[wptr] <= wr_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr == AW'(DEPTH - 1) ? '0 : wptr + AW'(1);
         if (do_rd) rptr <= rptr == AW'(DEPTH - 1) ? '0 : rptr + AW'(1);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end
endmodule

// File: rtl/cfg_rom_stream_rdr.sv
// cfg_rom_stream_rdr: issues credit-limited burst reads to a fixed-latency ROM
// and re-presents the returned entries as a valid/ready stream with a last flag.
module cfg_rom_stream_rdr
   import cfg_rom_pkg::*;
#(
   parameter int         ADDR_BITS = 6,
   parameter int         DATA_W    = 32,
   parameter logic [1:0] RDTYPE    = 2'd1,
   parameter int         CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [CNT_W-1:0]     req_len,
   output logic                 rom_me,
   output logic [ADDR_BITS-1:0] rom_addr,
   input  logic [DATA_W-1:0]    rom_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_last,
   output logic                 busy
);
   localparam int LAT = rd_lat(RDTYPE);
   localparam int FIFO_DEPTH = fifo_depth(RDTYPE);
   localparam int LD = LAT > 0 ? LAT : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   state_t state, state_nxt;
   logic [ADDR_BITS-1:0] cur_addr, addr_q;
   logic [CNT_W-1:0] remaining;
   logic [1:0] tag_pipe [LD];
   logic [CW-1:0] fifo_count, inflight;
   logic credit_ok, is_last, wr_en, wr_last, fifo_full, fifo_empty, pop, head_last;
   logic [DATA_W-1:0] head_data;
   assign is_last = remaining == '0;
   assign pop = out_valid && out_ready;
   assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
   assign rom_addr = rom_me ? cur_addr : addr_q;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (state == IDLE && req_valid) state_nxt = ISSUE;
      if (state == ISSUE && rom_me && is_last) state_nxt = DRAIN;
      if (state == DRAIN && pop && head_last) state_nxt = IDLE;
   end
   always_comb begin
      req_ready = state == IDLE;
      busy = state != IDLE;
      rom_me = state == ISSUE && credit_ok;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_addr <= '0;
         addr_q <= '0;
         remaining <= '0;
      end else if (req_valid && req_ready) begin
         cur_addr <= req_addr;
         remaining <= req_len;
      end else if (rom_me) begin
         cur_addr <= cur_addr + ADDR_BITS'(1);
         addr_q <= cur_addr;
         remaining <= remaining - CNT_W'(1);
      end
   end
   // {valid, last} tag per read, aligned so its exit coincides with the ROM data
   generate
      if (LAT == 0) begin : g_lat0
         assign tag_pipe[0] = 2'b00;
         assign wr_en = rom_me;
         assign wr_last = is_last;
      end else begin : g_latn
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < LAT; i++) tag_pipe[i] <= 2'b00;
            end else begin
               tag_pipe[0] <= {rom_me, is_last};
               for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            end
         end
         assign wr_en = tag_pipe[LAT-1][1];
         assign wr_last = tag_pipe[LAT-1][0];
      end
   endgenerate
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LD; i++) inflight = inflight + CW'(tag_pipe[i][1]);
   end
   cfg_sync_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en),
      .wr_data({wr_last, rom_rdata}),
      .rd_en(out_ready),
      .rd_data({head_last, head_data}),
      .full(fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );
   assign out_valid = !fifo_empty;
   assign out_data = out_valid ? head_data : '0;
   assign out_last = out_valid && head_last;
   assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && fifo_full && !pop));
endmodule

// File: tb/tb_cfg_rom_stream_rdr.sv
// tb_cfg_rom_stream_rdr: three readers (RDTYPE 0/1/3) against ROM models holding entry[i]=i,
// checked against a per-burst model of expected addresses, data, last flags and timing.
module tb_cfg_rom_stream_rdr;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid [3], req_ready [3], rom_me [3], out_valid [3], out_ready [3], out_last [3], busy [3];
   logic [5:0] req_addr [3], rom_addr [3];
   logic [7:0] req_len [3];
   logic [31:0] rom_rdata [3], out_data [3];
   int cyc = 0, vectors = 0, miscompares = 0;
   logic [31:0] cap_data [$];
   logic cap_last [$];
   int cap_cyc [$];
   logic [5:0] cap_addr [$];
   int acc_cyc [$];
   int max_out, stab_err;
   bit timed_out, drop_pending;
   logic busy_after, vld_after;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam logic [1:0] RT = g == 0 ? 2'd0 : g == 1 ? 2'd1 : 2'd3;
      logic [31:0] s1, s2;
      cfg_rom_stream_rdr #(.ADDR_BITS(6), .DATA_W(32), .RDTYPE(RT), .CNT_W(8)) dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_addr(req_addr[g]), .req_len(req_len[g]),
         .rom_me(rom_me[g]), .rom_addr(rom_addr[g]), .rom_rdata(rom_rdata[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]),
         .out_data(out_data[g]), .out_last(out_last[g]), .busy(busy[g])
      );
      // ROM returns garbage on cycles without a read so stray captures show up
      always @(posedge clk) begin
         s1 <= rom_me[g] ? {26'd0, rom_addr[g]} : {16'hBAD0, 16'($urandom)};
         s2 <= s1;
      end
      assign rom_rdata[g] = g == 0 ? (rom_me[g] ? {26'd0, rom_addr[g]} : 32'hBAD0_0000) : g == 1 ? s1 : s2;
   end

   task automatic request(input int d, input logic [5:0] a, input logic [7:0] l, output int ac);
      ac = -1;
      @(posedge clk); #1;
      req_valid[d] = 1'b1; req_addr[d] = a; req_len[d] = l;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready[d]) begin ac = cyc; break; end
         @(posedge clk); #1;
      end
      drop_pending = 1'b1;
      vectors++;
      if (ac < 0) begin miscompares++; $display("FAIL req_accept: dut %0d request not taken within 200 cycles", d); end
   endtask

   task automatic stream(input int d, input int nb, input bit rnd, input int stall_at);
      int pops, lasts, outst, stall_left;
      bit stalled, hold;
      logic [31:0] hd;
      logic hl;
      pops = 0; lasts = 0; outst = 0; stall_left = 0; stalled = 0; hold = 0; hd = '0; hl = 1'b0;
      cap_data.delete(); cap_last.delete(); cap_cyc.delete(); cap_addr.delete(); acc_cyc.delete();
      max_out = 0; stab_err = 0; timed_out = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         if (drop_pending) begin req_valid[d] = 1'b0; drop_pending = 1'b0; end
         if (!stalled && pops == stall_at) begin stalled = 1'b1; stall_left = 10; end
         out_ready[d] = stall_left > 0 ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall_left > 0) stall_left--;
         @(negedge clk);
         if (req_valid[d] && req_ready[d]) begin acc_cyc.push_back(cyc); drop_pending = 1'b1; end
         if (rom_me[d]) begin cap_addr.push_back(rom_addr[d]); outst++; end
         if (outst > max_out) max_out = outst;
         if (hold && (out_valid[d] !== 1'b1 || out_data[d] !== hd || out_last[d] !== hl)) stab_err++;
         hold = out_valid[d] && !out_ready[d]; hd = out_data[d]; hl = out_last[d];
         if (out_valid[d] && out_ready[d]) begin
            cap_data.push_back(out_data[d]); cap_last.push_back(out_last[d]); cap_cyc.push_back(cyc);
            pops++; outst--;
            if (out_last[d]) lasts++;
         end
         if (lasts == nb) begin timed_out = 1'b0; break; end
      end
      @(posedge clk); #1;
      out_ready[d] = 1'b1;
      if (drop_pending) begin req_valid[d] = 1'b0; drop_pending = 1'b0; end
      @(negedge clk);
      busy_after = busy[d]; vld_after = out_valid[d];
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({rom_me[d], rom_addr[d], out_valid[d], out_last[d], busy[d], req_ready[d]} !== 11'b0_000000_0001) begin
            miscompares++;
            $display("FAIL reset_ctl dut%0d: got me=%b addr=%0d vld=%b last=%b busy=%b rdy=%b, want 0 0 0 0 0 1",
                     d, rom_me[d], rom_addr[d], out_valid[d], out_last[d], busy[d], req_ready[d]);
         end
         vectors++;
         if (out_data[d] !== 32'd0) begin miscompares++; $display("FAIL reset_data dut%0d: got %0h want 0", d, out_data[d]); end
      end
   endtask

   task automatic test_basic();
      int ac;
      request(1, 6'd4, 8'd3, ac);
      stream(1, 1, 1'b0, -1);
      vectors++;
      if (timed_out || cap_data.size() != 4) begin miscompares++; $display("FAIL basic_count: got %0d beats (timeout %0b) want 4", cap_data.size(), timed_out); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cap_data[i] !== 32'(4 + i) || cap_last[i] !== (i == 3) || cap_cyc[i] != ac + 3 + i || cap_addr[i] !== 6'(4 + i)) begin
            miscompares++;
            $display("FAIL basic_beat%0d: got data %0h last %b cyc %0d addr %0d, want data %0h last %b cyc %0d addr %0d",
                     i, cap_data[i], cap_last[i], cap_cyc[i], cap_addr[i], 4 + i, i == 3, ac + 3 + i, 4 + i);
         end
      end
      vectors++;
      if (busy_after !== 1'b0) begin miscompares++; $display("FAIL basic_busy_drop: got %b want 0", busy_after); end
   endtask

   task automatic test_wrap();
      int ac;
      request(2, 6'd62, 8'd3, ac);
      stream(2, 1, 1'b0, -1);
      vectors++;
      if (timed_out || cap_data.size() != 4 || cap_addr.size() != 4) begin
         miscompares++; $display("FAIL wrap_count: got %0d beats %0d reads want 4 4", cap_data.size(), cap_addr.size());
      end
      vectors++;
      if (cap_cyc[0] - ac != 4) begin miscompares++; $display("FAIL wrap_latency: got %0d want 4", cap_cyc[0] - ac); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cap_addr[i] !== 6'((62 + i) % 64) || cap_data[i] !== 32'((62 + i) % 64) || cap_last[i] !== (i == 3)) begin
            miscompares++;
            $display("FAIL wrap_beat%0d: got addr %0d data %0h last %b want %0d %0h %b",
                     i, cap_addr[i], cap_data[i], cap_last[i], (62 + i) % 64, (62 + i) % 64, i == 3);
         end
      end
   endtask

   task automatic test_stall();
      int ac;
      logic [5:0] a;
      a = 6'($urandom);
      request(1, a, 8'd15, ac);
      stream(1, 1, 1'b1, 2);
      vectors++;
      if (timed_out || cap_data.size() != 16) begin miscompares++; $display("FAIL stall_count: got %0d beats want 16", cap_data.size()); end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (cap_data[i] !== 32'((a + i) % 64) || cap_last[i] !== (i == 15)) begin
            miscompares++; $display("FAIL stall_beat%0d: got %0h/%b want %0h/%b", i, cap_data[i], cap_last[i], (a + i) % 64, i == 15);
         end
      end
      vectors++;
      if (stab_err != 0) begin miscompares++; $display("FAIL stall_hold: got %0d unstable stall cycles want 0", stab_err); end
      vectors++;
      if (max_out > 3) begin miscompares++; $display("FAIL stall_credit: got %0d outstanding reads want at most 3", max_out); end
   endtask

   task automatic test_single();
      int ac;
      logic [5:0] a;
      a = 6'($urandom);
      request(0, a, 8'd0, ac);
      drop_pending = 1'b0;
      @(posedge clk); #1;
      req_addr[0] = a ^ 6'd1;
      @(negedge clk);
      vectors++;
      if (req_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
         miscompares++; $display("FAIL single_busy_reject: got rdy %b busy %b want 0 1", req_ready[0], busy[0]);
      end
      req_valid[0] = 1'b0;
      stream(0, 1, 1'b0, -1);
      vectors++;
      if (timed_out || cap_data.size() != 1 || cap_data[0] !== {26'd0, a} || cap_last[0] !== 1'b1) begin
         miscompares++; $display("FAIL single_beat: got %0d beats data %0h last %b want 1 %0h 1", cap_data.size(), cap_data[0], cap_last[0], a);
      end
      vectors++;
      if (cap_cyc[0] - ac != 2) begin miscompares++; $display("FAIL single_latency: got %0d want 2", cap_cyc[0] - ac); end
      vectors++;
      if (acc_cyc.size() != 0 || busy_after !== 1'b0) begin
         miscompares++; $display("FAIL single_end: got %0d extra accepts busy %b want 0 0", acc_cyc.size(), busy_after);
      end
   endtask

   task automatic test_reset_mid();
      int ac, pops, extra;
      pops = 0; extra = 0;
      request(1, 6'($urandom), 8'd7, ac);
      for (int c = 0; c < 100 && pops < 3; c++) begin
         @(posedge clk); #1;
         if (drop_pending) begin req_valid[1] = 1'b0; drop_pending = 1'b0; end
         @(negedge clk);
         if (out_valid[1] && out_ready[1]) pops++;
      end
      vectors++;
      if (pops != 3) begin miscompares++; $display("FAIL rstmid_pre: got %0d beats want 3", pops); end
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rom_me[1], rom_addr[1], out_valid[1], out_last[1], busy[1], req_ready[1]} !== 11'b0_000000_0001 || out_data[1] !== 32'd0) begin
         miscompares++;
         $display("FAIL rstmid_state: got me=%b addr=%0d vld=%b last=%b busy=%b rdy=%b data=%0h, want 0 0 0 0 0 1 0",
                  rom_me[1], rom_addr[1], out_valid[1], out_last[1], busy[1], req_ready[1], out_data[1]);
      end
      repeat (10) begin @(negedge clk); if (out_valid[1] || busy[1]) extra++; end
      vectors++;
      if (extra != 0) begin miscompares++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra); end
      request(1, 6'd0, 8'd1, ac);
      stream(1, 1, 1'b0, -1);
      vectors++;
      if (timed_out || cap_data.size() != 2 || cap_data[0] !== 32'd0 || cap_data[1] !== 32'd1 || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_restart: got %0d beats %0h/%b %0h/%b want 2 0/0 1/1",
                                 cap_data.size(), cap_data[0], cap_last[0], cap_data[1], cap_last[1]);
      end
   endtask

   task automatic test_back_to_back();
      int ac, n1, n2;
      logic [5:0] a1, a2;
      logic [31:0] ed;
      a1 = 6'($urandom); a2 = 6'($urandom);
      n1 = $urandom_range(3, 6); n2 = $urandom_range(2, 6);
      request(2, a1, 8'(n1 - 1), ac);
      drop_pending = 1'b0;
      @(posedge clk); #1;
      req_addr[2] = a2; req_len[2] = 8'(n2 - 1);
      @(negedge clk);
      vectors++;
      if (req_ready[2] !== 1'b0) begin miscompares++; $display("FAIL b2b_hold_off: got rdy %b want 0", req_ready[2]); end
      stream(2, 2, 1'b1, -1);
      vectors++;
      if (timed_out || cap_data.size() != n1 + n2 || acc_cyc.size() != 1) begin
         miscompares++; $display("FAIL b2b_count: got %0d beats %0d accepts want %0d 1", cap_data.size(), acc_cyc.size(), n1 + n2);
      end
      vectors++;
      if (acc_cyc[0] != cap_cyc[n1-1] + 1) begin
         miscompares++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc[0], cap_cyc[n1-1] + 1);
      end
      for (int i = 0; i < n1 + n2; i++) begin
         ed = i < n1 ? 32'((a1 + i) % 64) : 32'((a2 + i - n1) % 64);
         vectors++;
         if (cap_data[i] !== ed || cap_last[i] !== (i == n1 - 1 || i == n1 + n2 - 1)) begin
            miscompares++; $display("FAIL b2b_beat%0d: got %0h/%b want %0h/%b", i, cap_data[i], cap_last[i], ed, i == n1 - 1 || i == n1 + n2 - 1);
         end
      end
   endtask

   task automatic test_random();
      int ac, n;
      logic [5:0] a;
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 2; k++) begin
            a = 6'($urandom); n = $urandom_range(1, 21);
            request(d, a, 8'(n - 1), ac);
            stream(d, 1, 1'b1, -1);
            vectors++;
            if (timed_out || cap_data.size() != n || cap_addr.size() != n) begin
               miscompares++; $display("FAIL rand_count dut%0d: got %0d beats %0d reads want %0d", d, cap_data.size(), cap_addr.size(), n);
            end
            for (int i = 0; i < n; i++) begin
               vectors++;
               if (cap_data[i] !== 32'((a + i) % 64) || cap_last[i] !== (i == n - 1) || cap_addr[i] !== 6'((a + i) % 64)) begin
                  miscompares++;
                  $display("FAIL rand_beat dut%0d #%0d: got %0h/%b addr %0d want %0h/%b addr %0d",
                           d, i, cap_data[i], cap_last[i], cap_addr[i], (a + i) % 64, i == n - 1, (a + i) % 64);
               end
            end
            vectors++;
            if (max_out > d + 2 || stab_err != 0) begin
               miscompares++; $display("FAIL rand_flow dut%0d: got %0d outstanding %0d unstable want <=%0d 0", d, max_out, stab_err, d + 2);
            end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 1'b0; req_addr[d] = '0; req_len[d] = '0; out_ready[d] = 1'b1;
      end
      drop_pending = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_single();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
